// File: rtl/bw_clk_cmp_rst_seq.sv
// Global reset / cluster clock-enable sequencer for the CMP clock domain.
// Optional macro BW_CLK_CKEN_STAGGER_EN selects a staggered per-cluster enable ramp.
module bw_clk_cmp_rst_seq #(
    parameter int NUM_CLUST = 4,
    parameter int RST_CYC   = 16,
    parameter int STAGGER   = 4,
    parameter int DBG_CYC   = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 gclk,
    input  logic                 arst_l,
    input  logic                 wrst_req,
    input  logic                 dbg_req,
    input  logic [NUM_CLUST-1:0] cken_mask,
    output logic                 grst_l,
    output logic                 gdbginit_l,
    output logic [NUM_CLUST-1:0] cluster_cken,
    output logic                 seq_busy,
    output logic                 seq_done
);

    typedef enum logic [1:0] {
        RST_HOLD   = 2'd0,
        CKEN_RAMP  = 2'd1,
        RUN        = 2'd2,
        DBG_ASSERT = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] DBG_LAST = CNT_W'(DBG_CYC - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CLUST-1:0]   cken_q, cken_d;
    logic                   grst_q, grst_d;
    logic                   gdbg_q, gdbg_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   wrst_s_q, wrst_p_q;
    logic                   dbg_s_q, dbg_p_q;
    logic                   wrst_edge, dbg_edge;

`ifdef BW_CLK_CKEN_STAGGER_EN
    localparam int IDX_W = (NUM_CLUST > 1) ? $clog2(NUM_CLUST) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLUST - 1);
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_CLUST-1:0]   slot_bit;

    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) idx_q <= '0;
        else         idx_q <= idx_d;
    end

    assign slot_bit = NUM_CLUST'(1) << (idx_q + IDX_W'(1));
`endif

    // Request edges: sampled at edge k, previous sample from edge k-1, acted on at k+1.
    assign wrst_edge = wrst_s_q & ~wrst_p_q;
    assign dbg_edge  = dbg_s_q & ~dbg_p_q;

    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q  <= RST_HOLD;
            cnt_q    <= '0;
            cken_q   <= '0;
            grst_q   <= 1'b0;
            gdbg_q   <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            wrst_s_q <= 1'b0;
            wrst_p_q <= 1'b0;
            dbg_s_q  <= 1'b0;
            dbg_p_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cken_q   <= cken_d;
            grst_q   <= grst_d;
            gdbg_q   <= gdbg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wrst_s_q <= wrst_req;
            wrst_p_q <= wrst_s_q;
            dbg_s_q  <= dbg_req;
            dbg_p_q  <= dbg_s_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        cken_d  = cken_q;
        grst_d  = grst_q;
        gdbg_d  = gdbg_q;
        done_d  = 1'b0;
`ifdef BW_CLK_CKEN_STAGGER_EN
        idx_d   = idx_q;
`endif
        if (wrst_edge) begin
            // Warm reset overrides everything, including a same-cycle debug request.
            state_d = RST_HOLD;
            cnt_d   = '0;
            cken_d  = '0;
            grst_d  = 1'b0;
            gdbg_d  = 1'b0;
        end else begin
            case (state_q)
                RST_HOLD: begin
                    cken_d = '0;
                    grst_d = 1'b0;
                    gdbg_d = 1'b0;
                    if (cnt_q == RST_LAST) begin
                        state_d = CKEN_RAMP;
                        cnt_d   = '0;
`ifdef BW_CLK_CKEN_STAGGER_EN
                        idx_d   = '0;
                        cken_d  = cken_mask & NUM_CLUST'(1);
`else
                        cken_d  = cken_mask;
`endif
                    end
                end
                CKEN_RAMP: begin
                    if (cnt_q == STG_LAST) begin
                        cnt_d = '0;
`ifdef BW_CLK_CKEN_STAGGER_EN
                        // Masked clusters still consume their slot.
                        if (idx_q == LAST_IDX) begin
                            state_d = RUN;
                            grst_d  = 1'b1;
                            gdbg_d  = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            idx_d  = idx_q + IDX_W'(1);
                            cken_d = cken_q | (cken_mask & slot_bit);
                        end
`else
                        state_d = RUN;
                        grst_d  = 1'b1;
                        gdbg_d  = 1'b1;
                        done_d  = 1'b1;
`endif
                    end
                end
                RUN: begin
                    cken_d = cken_mask;
                    cnt_d  = '0;
                    if (dbg_edge) begin
                        state_d = DBG_ASSERT;
                        gdbg_d  = 1'b0;
                    end
                end
                default: begin
                    cken_d = cken_mask;
                    if (cnt_q == DBG_LAST) begin
                        state_d = RUN;
                        gdbg_d  = 1'b1;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end
            endcase
        end
        busy_d = (state_d != RUN);
    end

    assign grst_l       = grst_q;
    assign gdbginit_l   = gdbg_q;
    assign cluster_cken = cken_q;
    assign seq_busy     = busy_q;
    assign seq_done     = done_q;

endmodule
